// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_controller
//  Description : 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
//                Issues framebuffer reads through a fixed-latency read port.
//                Delivers pipeline-aligned RGB, syncs and blanking to
//                vga_adapter.
//  Optional    : VGA_TEST_PATTERN_EN enables internal colour bars, which are
//                selected per pixel by test_pattern.
//  Ports       : clk, rst            - pixel clock, sync active-high reset
//                fb_read/fb_x/fb_y   - framebuffer request (zero when idle)
//                fb_data             - {r,g,b}, FETCH_LATENCY after request
//                test_pattern        - colour-bar select (macro builds only)
//                r, g, b             - 4-bit colour, 0 during blanking
//                horizontal_sync     - level set by SYNC_ACTIVE
//                vertical_sync       - level set by SYNC_ACTIVE
//                video_output        - active-video flag
//                frame_start         - pulse one cycle after counters hit (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_controller #(
   parameter int   H_VISIBLE     = 640,
   parameter int   H_FRONT       = 16,
   parameter int   H_SYNC        = 96,
   parameter int   H_BACK        = 48,
   parameter int   V_VISIBLE     = 480,
   parameter int   V_FRONT       = 10,
   parameter int   V_SYNC        = 2,
   parameter int   V_BACK        = 33,
   parameter logic SYNC_ACTIVE   = 1'b0,
   parameter int   FETCH_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fb_read,
   output logic [9:0]  fb_x,
   output logic [9:0]  fb_y,
   input  logic [11:0] fb_data,
   input  logic        test_pattern,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        horizontal_sync,
   output logic        vertical_sync,
   output logic        video_output,
   output logic        frame_start
);

   // Pipeline depth from counter state to the outputs.
   localparam int        c_L        = FETCH_LATENCY + 1;
   localparam logic [9:0] c_H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] c_HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] c_VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0]     r_h;
   logic [9:0]     r_v;
   logic           w_vis;
   logic           w_hs;
   logic           w_vs;
   logic           w_pat;
   logic [c_L:1]   r_vis_d;
   logic [c_L:1]   r_hs_d;
   logic [c_L:1]   r_vs_d;
   logic [11:0]    w_colour;
   logic [11:0]    r_rgb;
   logic           r_frame_start;

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_h == c_H_LAST) begin
         r_h <= '0;
         r_v <= (r_v == c_V_LAST) ? '0 : r_v + 10'd1;
      end else begin
         r_h <= r_h + 10'd1;
      end
   end

   // Stage 0: decode straight from the counters
   assign w_vis = (r_h < c_H_VIS) && (r_v < c_V_VIS);
   assign w_hs  = (r_h >= c_HS_FIRST) && (r_h <= c_HS_LAST);
   assign w_vs  = (r_v >= c_VS_FIRST) && (r_v <= c_VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
   // Pattern select and bar index travel alongside vis so the bar colour
   // lands in the same cycle a fetched pixel would.
   logic [FETCH_LATENCY:1] r_pat_d;
   logic [2:0]             r_bar_d [1:FETCH_LATENCY];

   assign w_pat = test_pattern;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i <= FETCH_LATENCY; i++) begin
            r_pat_d[i] <= 1'b0;
            r_bar_d[i] <= 3'd0;
         end
      end else begin
         for (int i = FETCH_LATENCY; i >= 2; i--) begin
            r_pat_d[i] <= r_pat_d[i-1];
            r_bar_d[i] <= r_bar_d[i-1];
         end
         r_pat_d[1] <= test_pattern;
         r_bar_d[1] <= r_h[9:7];
      end
   end

   always_comb begin
      w_colour = fb_data;
      if (r_pat_d[FETCH_LATENCY]) begin
         w_colour = {{4{r_bar_d[FETCH_LATENCY][0]}},
                     {4{r_bar_d[FETCH_LATENCY][1]}},
                     {4{r_bar_d[FETCH_LATENCY][2]}}};
      end
   end
`else
   // Port kept for pin compatibility; the framebuffer path is always used.
   logic w_unused_test_pattern;
   assign w_unused_test_pattern = test_pattern;
   assign w_pat    = 1'b0;
   assign w_colour = fb_data;
`endif

   // ------------------------------------------------------------------
   // Framebuffer request: suppressed during reset and while bars are shown
   // ------------------------------------------------------------------
   assign fb_read = w_vis & ~rst & ~w_pat;
   assign fb_x    = fb_read ? r_h : 10'd0;
   assign fb_y    = fb_read ? r_v : 10'd0;

   // ------------------------------------------------------------------
   // Control delay line; stage FETCH_LATENCY lines up with fb_data
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vis_d       <= '0;
         r_hs_d        <= '0;
         r_vs_d        <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_vis_d       <= {r_vis_d[c_L-1:1], w_vis};
         r_hs_d        <= {r_hs_d[c_L-1:1], w_hs};
         r_vs_d        <= {r_vs_d[c_L-1:1], w_vs};
         r_frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
      end
   end

   // Colour register loads only for visible pixels, so blanking is black
   // no matter what the read port returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb <= '0;
      end else if (r_vis_d[FETCH_LATENCY]) begin
         r_rgb <= w_colour;
      end else begin
         r_rgb <= '0;
      end
   end

   assign r               = r_rgb[11:8];
   assign g               = r_rgb[7:4];
   assign b               = r_rgb[3:0];
   assign video_output    = r_vis_d[c_L];
   assign horizontal_sync = r_hs_d[c_L] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vertical_sync   = r_vs_d[c_L] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign frame_start     = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_timing_controller
//  Description : Directed self-checking bench for vga_timing_controller.
//                Horizontal timing is the standard 800-pixel line; the frame
//                is shortened to 27 lines (20 visible, sync on lines 22-23)
//                to keep run time short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        test_pattern = 1'b0;
   logic        fb_read;
   logic [9:0]  fb_x;
   logic [9:0]  fb_y;
   logic [11:0] fb_data;
   logic [3:0]  r;
   logic [3:0]  g;
   logic [3:0]  b;
   logic        horizontal_sync;
   logic        vertical_sync;
   logic        video_output;
   logic        frame_start;
   wire  [11:0] rgb = {r, g, b};

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   vga_timing_controller #(
      .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut (
      .clk(clk), .rst(rst), .fb_read(fb_read), .fb_x(fb_x), .fb_y(fb_y),
      .fb_data(fb_data), .test_pattern(test_pattern), .r(r), .g(g), .b(b),
      .horizontal_sync(horizontal_sync), .vertical_sync(vertical_sync),
      .video_output(video_output), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Framebuffer: two-cycle read latency, data = {y[3:0], x[7:0]},
   // all-ones when no request is outstanding.
   logic       q1_v = 1'b0, q2_v = 1'b0;
   logic [9:0] q1_x, q1_y, q2_x, q2_y;
   always @(posedge clk) begin
      q1_v <= fb_read; q1_x <= fb_x; q1_y <= fb_y;
      q2_v <= q1_v;    q2_x <= q1_x; q2_y <= q1_y;
   end
   assign fb_data = q2_v ? {q2_y[3:0], q2_x[7:0]} : 12'hFFF;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic tick_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (video_output !== 1'b0) $display("FAIL rst_vo got=%0b exp=0", video_output); else passes++;
      checks++; if (rgb !== 12'h000) $display("FAIL rst_rgb got=%h exp=000", rgb); else passes++;
      checks++; if (horizontal_sync !== 1'b1) $display("FAIL rst_hsync got=%0b exp=1", horizontal_sync); else passes++;
      checks++; if (vertical_sync !== 1'b1) $display("FAIL rst_vsync got=%0b exp=1", vertical_sync); else passes++;
      checks++; if (fb_read !== 1'b0) $display("FAIL rst_fb_read got=%0b exp=0", fb_read); else passes++;
      checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start got=%0b exp=0", frame_start); else passes++;
      checks++; if (fb_x !== 10'd0) $display("FAIL rst_fb_x got=%0d exp=0", fb_x); else passes++;
      checks++; if (fb_y !== 10'd0) $display("FAIL rst_fb_y got=%0d exp=0", fb_y); else passes++;
      rst = 1'b0;
      cyc = 0;
      #1;
      checks++; if (fb_read !== 1'b1) $display("FAIL c0_fb_read got=%0b exp=1", fb_read); else passes++;
      checks++; if (fb_x !== 10'd0 || fb_y !== 10'd0) $display("FAIL c0_fb_xy got=%0d,%0d exp=0,0", fb_x, fb_y); else passes++;
      checks++; if (frame_start !== 1'b0) $display("FAIL c0_frame_start got=%0b exp=0", frame_start); else passes++;
   endtask

   task automatic test_first_pixels();
      tick();
      checks++; if (frame_start !== 1'b1) $display("FAIL c1_frame_start got=%0b exp=1", frame_start); else passes++;
      checks++; if (video_output !== 1'b0) $display("FAIL c1_vo got=%0b exp=0", video_output); else passes++;
      tick();
      checks++; if (frame_start !== 1'b0) $display("FAIL c2_frame_start got=%0b exp=0", frame_start); else passes++;
      checks++; if (video_output !== 1'b0) $display("FAIL c2_vo got=%0b exp=0", video_output); else passes++;
      tick();
      checks++; if (video_output !== 1'b1) $display("FAIL c3_vo got=%0b exp=1", video_output); else passes++;
      checks++; if (rgb !== 12'h000) $display("FAIL c3_rgb got=%h exp=000", rgb); else passes++;
      tick();
      checks++; if (rgb !== 12'h001) $display("FAIL c4_rgb got=%h exp=001", rgb); else passes++;
   endtask

   task automatic test_fetch_path();
      tick_to(7 * 800 + 5);
      checks++; if (fb_read !== 1'b1) $display("FAIL px57_fb_read got=%0b exp=1", fb_read); else passes++;
      checks++; if (fb_x !== 10'd5 || fb_y !== 10'd7) $display("FAIL px57_fb_xy got=%0d,%0d exp=5,7", fb_x, fb_y); else passes++;
      tick_to(7 * 800 + 5 + 3);
      checks++; if (rgb !== 12'h705) $display("FAIL px57_rgb got=%h exp=705", rgb); else passes++;
      checks++; if (video_output !== 1'b1) $display("FAIL px57_vo got=%0b exp=1", video_output); else passes++;
      tick_to(7 * 800 + 700);
      checks++; if (fb_read !== 1'b0) $display("FAIL blank_fb_read got=%0b exp=0", fb_read); else passes++;
      checks++; if (fb_x !== 10'd0 || fb_y !== 10'd0) $display("FAIL blank_fb_xy got=%0d,%0d exp=0,0", fb_x, fb_y); else passes++;
      tick_to(7 * 800 + 703);
      checks++; if (rgb !== 12'h000) $display("FAIL blank_rgb got=%h exp=000", rgb); else passes++;
      checks++; if (video_output !== 1'b0) $display("FAIL blank_vo got=%0b exp=0", video_output); else passes++;
   endtask

   task automatic test_hsync();
      int hs_first = -1, hs_last = -1, hs_cnt = 0, vo_first = -1, vo_cnt = 0;
      tick_to(8 * 800);
      repeat (800) begin
         if (!horizontal_sync) begin
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            hs_cnt++;
         end
         if (video_output) begin
            if (vo_first < 0) vo_first = cyc;
            vo_cnt++;
         end
         tick();
      end
      checks++; if (hs_first != 6400 + 659) $display("FAIL hs_first got=%0d exp=%0d", hs_first, 6400 + 659); else passes++;
      checks++; if (hs_last != 6400 + 754) $display("FAIL hs_last got=%0d exp=%0d", hs_last, 6400 + 754); else passes++;
      checks++; if (hs_cnt != 96) $display("FAIL hs_width got=%0d exp=96", hs_cnt); else passes++;
      checks++; if (vo_first != 6403) $display("FAIL vo_first got=%0d exp=6403", vo_first); else passes++;
      checks++; if (vo_cnt != 640) $display("FAIL vo_width got=%0d exp=640", vo_cnt); else passes++;
   endtask

   task automatic test_frame();
      int lines = 0, vo_cnt = 0, run = 0, run_min = 100000, run_max = 0;
      int hs_cnt = 0, vs_cnt = 0, vs_first = -1, fs_cnt = 0, fs_a = -1, fs_b = -1;
      logic prev_vo = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (cyc <= 21602) begin
         if (video_output) begin
            vo_cnt++;
            run++;
            if (!prev_vo) lines++;
         end else if (prev_vo) begin
            if (run < run_min) run_min = run;
            if (run > run_max) run_max = run;
            run = 0;
         end
         prev_vo = video_output;
         if (!horizontal_sync) hs_cnt++;
         if (!vertical_sync) begin
            if (vs_first < 0) vs_first = cyc;
            vs_cnt++;
         end
         if (frame_start) begin
            fs_cnt++;
            if (fs_a < 0) fs_a = cyc; else fs_b = cyc;
         end
         tick();
      end
      checks++; if (lines != 20) $display("FAIL frame_lines got=%0d exp=20", lines); else passes++;
      checks++; if (vo_cnt != 12800) $display("FAIL frame_vo_total got=%0d exp=12800", vo_cnt); else passes++;
      checks++; if (run_min != 640 || run_max != 640) $display("FAIL frame_vo_run got=%0d..%0d exp=640", run_min, run_max); else passes++;
      checks++; if (hs_cnt != 27 * 96) $display("FAIL frame_hs_total got=%0d exp=%0d", hs_cnt, 27 * 96); else passes++;
      checks++; if (vs_cnt != 1600) $display("FAIL frame_vs_width got=%0d exp=1600", vs_cnt); else passes++;
      checks++; if (vs_first != 22 * 800 + 3) $display("FAIL frame_vs_first got=%0d exp=%0d", vs_first, 22 * 800 + 3); else passes++;
      checks++; if (fs_cnt != 2) $display("FAIL frame_fs_count got=%0d exp=2", fs_cnt); else passes++;
      checks++; if (fs_a != 1) $display("FAIL frame_fs_first got=%0d exp=1", fs_a); else passes++;
      checks++; if (fs_b != 21601) $display("FAIL frame_fs_second got=%0d exp=21601", fs_b); else passes++;
   endtask

   task automatic test_midframe_reset();
      tick_to(21600 + 10 * 800 + 300);
      checks++; if (video_output !== 1'b1) $display("FAIL mid_pre_vo got=%0b exp=1", video_output); else passes++;
      checks++; if (rgb !== 12'hA29) $display("FAIL mid_pre_rgb got=%h exp=a29", rgb); else passes++;
      rst = 1'b1;
      #1;
      checks++; if (fb_read !== 1'b0) $display("FAIL mid_rst_fb_read got=%0b exp=0", fb_read); else passes++;
      tick();
      checks++; if (video_output !== 1'b0) $display("FAIL mid_rst_vo got=%0b exp=0", video_output); else passes++;
      checks++; if (rgb !== 12'h000) $display("FAIL mid_rst_rgb got=%h exp=000", rgb); else passes++;
      checks++; if (horizontal_sync !== 1'b1 || vertical_sync !== 1'b1) $display("FAIL mid_rst_sync got=%0b%0b exp=11", horizontal_sync, vertical_sync); else passes++;
      rst = 1'b0;
      cyc = 0;
      #1;
      checks++; if (fb_read !== 1'b1 || fb_x !== 10'd0 || fb_y !== 10'd0) $display("FAIL mid_c0_req got=%0b(%0d,%0d) exp=1(0,0)", fb_read, fb_x, fb_y); else passes++;
      tick();
      checks++; if (frame_start !== 1'b1) $display("FAIL mid_c1_frame_start got=%0b exp=1", frame_start); else passes++;
      checks++; if (video_output !== 1'b0 || rgb !== 12'h000) $display("FAIL mid_c1_out got=%0b/%h exp=0/000", video_output, rgb); else passes++;
      tick();
      checks++; if (video_output !== 1'b0 || rgb !== 12'h000) $display("FAIL mid_c2_out got=%0b/%h exp=0/000", video_output, rgb); else passes++;
      tick();
      checks++; if (video_output !== 1'b1 || rgb !== 12'h000) $display("FAIL mid_c3_out got=%0b/%h exp=1/000", video_output, rgb); else passes++;
      tick();
      checks++; if (rgb !== 12'h001) $display("FAIL mid_c4_rgb got=%h exp=001", rgb); else passes++;
   endtask

   task automatic test_pattern_input();
      int rd_cnt = 0;
      logic [11:0] c5, c130, c300, c400, c600;
      test_pattern = 1'b1;
      tick_to(2 * 800);
      repeat (800) begin
         if (fb_read) rd_cnt++;
         if (cyc == 1603 + 5)   c5   = rgb;
         if (cyc == 1603 + 130) c130 = rgb;
         if (cyc == 1603 + 300) c300 = rgb;
         if (cyc == 1603 + 400) c400 = rgb;
         if (cyc == 1603 + 600) c600 = rgb;
         tick();
      end
`ifdef VGA_TEST_PATTERN_EN
      checks++; if (rd_cnt != 0) $display("FAIL pat_fb_read got=%0d exp=0", rd_cnt); else passes++;
      checks++; if (c5 !== 12'h000) $display("FAIL pat_x5 got=%h exp=000", c5); else passes++;
      checks++; if (c130 !== 12'hF00) $display("FAIL pat_x130 got=%h exp=f00", c130); else passes++;
      checks++; if (c300 !== 12'h0F0) $display("FAIL pat_x300 got=%h exp=0f0", c300); else passes++;
      checks++; if (c400 !== 12'hFF0) $display("FAIL pat_x400 got=%h exp=ff0", c400); else passes++;
      checks++; if (c600 !== 12'h00F) $display("FAIL pat_x600 got=%h exp=00f", c600); else passes++;
`else
      checks++; if (rd_cnt != 640) $display("FAIL nopat_fb_read got=%0d exp=640", rd_cnt); else passes++;
      checks++; if (c5 !== 12'h205) $display("FAIL nopat_x5 got=%h exp=205", c5); else passes++;
      checks++; if (c130 !== 12'h282) $display("FAIL nopat_x130 got=%h exp=282", c130); else passes++;
      checks++; if (c300 !== 12'h22C) $display("FAIL nopat_x300 got=%h exp=22c", c300); else passes++;
      checks++; if (c400 !== 12'h290) $display("FAIL nopat_x400 got=%h exp=290", c400); else passes++;
      checks++; if (c600 !== 12'h258) $display("FAIL nopat_x600 got=%h exp=258", c600); else passes++;
`endif
      test_pattern = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_pixels();
      test_fetch_path();
      test_hsync();
      test_frame();
      test_midframe_reset();
      test_pattern_input();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_controller.md
# vga_timing_controller

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It also sequences pixel fetches from the framebuffer through a fixed-latency read port. It delivers 4-bit RGB, `horizontal_sync`, `vertical_sync` and `video_output` to `vga_adapter`, all pipeline-aligned. It is the only driver of `vga_adapter`'s inputs.

## Interface

One clock; reset is synchronous and active-high. Ports are `clk` and `rst`.

Parameters:
- `H_VISIBLE`, default 640: active pixels per line
- `H_FRONT`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: horizontal sync width, in pixels
- `H_BACK`, default 48: horizontal back porch, in pixels
- `V_VISIBLE`, default 480: active lines
- `V_FRONT`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vertical sync width, in lines
- `V_BACK`, default 33: vertical back porch, in lines
- `SYNC_ACTIVE`, default 0: sync asserted level (0 = active-low)
- `FETCH_LATENCY`, default 2: framebuffer read latency in cycles; must be ≥1

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous active-high reset
- `fb_read`  out  1  framebuffer read strobe
- `fb_x`  out  10  pixel column of the request
- `fb_y`  out  10  pixel row of the request
- `fb_data`  in  12  {r,g,b}; valid exactly `FETCH_LATENCY` cycles after the request cycle
- `test_pattern`  in  1  selects the internal colour bars (see Configuration)
- `r`, `g`, `b`  out  4 each  pixel colour
- `horizontal_sync`  out  1  horizontal sync
- `vertical_sync`  out  1  vertical sync
- `video_output`  out  1  active-video flag (drives `vga_blank_n`)
- `frame_start`  out  1  one-cycle pulse when the counters are at (0,0), undelayed

## Operation

- Derived totals: H_TOTAL = 800, V_TOTAL = 525.
- Counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) are registered.
- Each cycle `h` increments.
  - At `h` = H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - At (`h`,`v`) = (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Stage 0 is combinational from the counters:
  - `vis` = (`h` < H_VISIBLE) && (`v` < V_VISIBLE)
  - `hs` = `h` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
  - `vs` = `v` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], applied to the whole line
- Framebuffer port:
  - `fb_read` = `vis`, and is 0 while the pattern is active.
  - `fb_x` = `h`, `fb_y` = `v`.
  - Both are zero when `fb_read` = 0.
- `vis`, `hs` and `vs` pass through a delay line of L = FETCH_LATENCY+1 registers.
- Colour register:
  - Loads `fb_data` (or pattern colour) in the cycle the delayed `vis` reaches stage FETCH_LATENCY; otherwise loads 0.
  - Outputs are therefore forced to 0 whenever `video_output` = 0.
- Output sync level:
  - `horizontal_sync` = `hs`_delayed ? SYNC_ACTIVE : ~SYNC_ACTIVE
  - `vertical_sync` follows the same rule using `vs`_delayed.
- `frame_start` = (`h`==0 && `v`==0), registered from the counter state; it is not delayed.

## Timing

- Output latency: every output tracks counter state by exactly L cycles (3 at default).
- Data path: `fb_data` presented in cycle t+FETCH_LATENCY for the request in cycle t appears on `r/g/b` in cycle t+L.
- Reset values:
  - `h` = `v` = 0
  - delay line cleared (vis = 0, hs = vs = deasserted)
  - `r/g/b` = 0, `video_output` = 0
  - syncs at ~SYNC_ACTIVE (1 at default)
  - `fb_read` = 0, `frame_start` = 0
- While `rst` is high, `fb_read` is held 0.
- First cycle after reset release:
  - counters = (0,0) and `fb_read` = 1
  - `frame_start` = 1 one cycle later
  - first active pixel on outputs at cycle L
- Reset mid-frame: the next cycle restarts at (0,0) with the pipeline empty. No stale pixel or sync reaches the outputs; outputs hold reset values for L cycles.
- Per line at the outputs:
  - `video_output` high for exactly H_VISIBLE consecutive cycles
  - `horizontal_sync` asserted for exactly H_SYNC cycles
- Per frame: `vertical_sync` asserted for V_SYNC×H_TOTAL cycles, starting at `h` = 0.

## Configuration

- Macro `VGA_TEST_PATTERN_EN`.
- Defined, with `test_pattern` = 1:
  - `fb_read` is held 0.
  - Colour is generated from delayed x: bar = x[9:7]; `r` = {4{bar[0]}}, `g` = {4{bar[1]}}, `b` = {4{bar[2]}}.
  - Latency is the same as the framebuffer path.
  - `test_pattern` is sampled per pixel at stage 0.
- Not defined: `test_pattern` is ignored; the port remains and the framebuffer path is always used.

## Test plan

- Reset then run 1 frame (420000 cycles):
  - exactly 480 lines of 640 `video_output`-high cycles
  - `frame_start` pulses at cycles 1 and 420001
- Horizontal sync: `horizontal_sync` low from output cycle 656+3 to 751+3 of each line; high elsewhere.
- Vertical sync: `vertical_sync` low for 1600 cycles beginning at line 490, `h` = 0 (+3 cycles).
- Framebuffer model with `FETCH_LATENCY` = 2 returning data = {fb_y[3:0], fb_x[7:0]}: output pixel (5,7) shows `r/g/b` = 0x705 exactly 3 cycles after its request; blanking shows 0x000 even when `fb_data` = 0xFFF.
- Assert `rst` for 1 cycle at (h=300, v=200): outputs return to reset values within 1 cycle; next active pixel is (0,0) at cycle L after release; `fb_read` = 0 while `rst` = 1.
- With `VGA_TEST_PATTERN_EN` and `test_pattern` = 1:
  - x = 0..127 → 0x000
  - x = 128..255 → 0xF00
  - x = 256..383 → 0x0F0
  - `fb_read` never asserted
